// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, stall encoding and bus layouts for the memory stage
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD       = 76;
    localparam int MEM_TO_WB_WD       = 70;
    localparam int MEM_TO_ID_WD       = 38;
    localparam int STALL_WD           = 6;
    localparam int LOAD_SRAM_DATA_WD  = 5;
    localparam int STORE_SRAM_DATA_WD = 3;

    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    localparam logic        STOP      = 1'b1;
    localparam logic        NO_STOP   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef logic [STALL_WD-1:0] stall_bus_t;

    typedef struct packed {
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
    } load_flags_t;

    typedef struct packed {
        logic sb;
        logic sh;
        logic sw;
    } store_flags_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - extracts and extends the addressed byte/half/word of load data
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  load_flags_t load_flags,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*offset +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        ext_data = ZERO_WORD;
        if (load_flags.lb) begin
            ext_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_flags.lbu) begin
            ext_data = {24'h000000, byte_sel};
        end else if (load_flags.lh) begin
            ext_data = {{16{half_sel[15]}}, half_sel};
        end else if (load_flags.lhu) begin
            ext_data = {16'h0000, half_sel};
        end else if (load_flags.lw) begin
            ext_data = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage; MEM_ALIGN_CHK_EN enables the misalignment check
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [STALL_WD-1:0]           stall,
    input  logic [EX_TO_MEM_WD-1:0]       ex_to_mem_bus,
    input  logic [LOAD_SRAM_DATA_WD-1:0]  load_sram_ex_data,
    input  logic [STORE_SRAM_DATA_WD-1:0] store_sram_ex_data,
    input  logic [31:0]                   data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0]       mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0]       mem_to_id_bus,
    output logic                          mem_addr_err
);

    ex_to_mem_t   ex_q, ex_d;
    load_flags_t  ld_q, ld_d;
    store_flags_t st_q, st_d;
    logic         hold_valid_q, hold_valid_d;
    logic [31:0]  hold_data_q, hold_data_d;

    logic        is_load;
    logic [1:0]  addr_off;
    logic [31:0] rdata_eff;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        load_err;
    logic        rf_we_out;
    logic        unused_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            ld_q         <= '0;
            st_q         <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= ZERO_WORD;
        end else begin
            ex_q         <= ex_d;
            ld_q         <= ld_d;
            st_q         <= st_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign is_load  = |ld_q;
    assign addr_off = ex_q.ex_result[1:0];

    always_comb begin
        ex_d         = ex_q;
        ld_d         = ld_q;
        st_d         = st_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP) begin
            ex_d = '0;
            ld_d = '0;
            st_d = '0;
        end else if (stall[STALL_MEM] == NO_STOP) begin
            ex_d = ex_to_mem_bus;
            ld_d = load_sram_ex_data;
            st_d = store_sram_ex_data;
        end
        // SRAM data is only valid in the load's first MEM cycle, so latch it once per stall
        if (stall[STALL_MEM] == NO_STOP) begin
            hold_valid_d = 1'b0;
        end else if (is_load && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_data_d  = data_sram_rdata;
        end
    end

    assign rdata_eff = hold_valid_q ? hold_data_q : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .rdata      (rdata_eff),
        .offset     (addr_off),
        .load_flags (ld_q),
        .ext_data   (load_data)
    );

`ifdef MEM_ALIGN_CHK_EN
    assign mem_addr_err = ((ld_q.lh | ld_q.lhu | st_q.sh) & addr_off[0])
                        | ((ld_q.lw | st_q.sw) & (addr_off != 2'b00));
    assign load_err     = mem_addr_err & is_load;
`else
    assign mem_addr_err = 1'b0;
    assign load_err     = 1'b0;
`endif

    assign rf_wdata  = ex_q.sel_rf_res ? load_data : ex_q.ex_result;
    assign rf_we_out = ex_q.rf_we & ~load_err;

    assign mem_to_wb_bus = {ex_q.pc, rf_we_out, ex_q.rf_waddr, rf_wdata};
    assign mem_to_id_bus = {rf_we_out & (ex_q.rf_waddr != 5'd0), ex_q.rf_waddr, rf_wdata};

    assign unused_ok = ^{ex_q.data_ram_en, ex_q.data_ram_wen, st_q, stall[2:0], stall[5]};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed load/store/stall vectors
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [75:0] ex_to_mem_bus;
    logic [4:0]  load_sram_ex_data;
    logic [2:0]  store_sram_ex_data;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id_bus;
    logic        mem_addr_err;

    mem_stage dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .ex_to_mem_bus      (ex_to_mem_bus),
        .load_sram_ex_data  (load_sram_ex_data),
        .store_sram_ex_data (store_sram_ex_data),
        .data_sram_rdata    (data_sram_rdata),
        .mem_to_wb_bus      (mem_to_wb_bus),
        .mem_to_id_bus      (mem_to_id_bus),
        .mem_addr_err       (mem_addr_err)
    );

    localparam logic [4:0] LB  = 5'b10000;
    localparam logic [4:0] LH  = 5'b01000;
    localparam logic [4:0] LW  = 5'b00100;
    localparam logic [4:0] LBU = 5'b00010;
    localparam logic [4:0] LHU = 5'b00001;
    localparam logic [2:0] SW  = 3'b001;
    localparam logic [5:0] GO     = 6'b000000;
    localparam logic [5:0] HOLD   = 6'b011111;
    localparam logic [5:0] BUBBLE = 6'b001111;

    typedef struct {
        int          cyc;
        logic [69:0] wb;
        logic [37:0] id;
        logic        err;
        bit          chk_hv;
        logic        hv;
    } exp_t;

    exp_t sb_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [75:0] mk_ex(input logic [31:0] pc, input logic sel,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] res, input logic en);
        return {pc, en, 4'b0000, sel, we, wa, res};
    endfunction

    function automatic void push_exp(input int dc, input logic [31:0] pc, input logic we,
                                     input logic [4:0] wa, input logic [31:0] wd,
                                     input logic err, input bit chk_hv, input logic hv);
        exp_t e;
        e.cyc    = cyc + dc;
        e.wb     = {pc, we, wa, wd};
        e.id     = {we && (wa != 5'd0), wa, wd};
        e.err    = err;
        e.chk_hv = chk_hv;
        e.hv     = hv;
        sb_q.push_back(e);
    endfunction

    task automatic drive(input logic [75:0] ex, input logic [4:0] ld, input logic [2:0] st,
                         input logic [31:0] rd, input logic [5:0] stl);
        @(posedge clk);
        #1;
        ex_to_mem_bus      = ex;
        load_sram_ex_data  = ld;
        store_sram_ex_data = st;
        data_sram_rdata    = rd;
        stall              = stl;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL stale_expect cyc=%0d actual_cycle=%0d required_cycle=%0d", cyc, cyc, e.cyc);
            end else begin
                if (mem_to_wb_bus !== e.wb) begin
                    bad++;
                    $display("FAIL wb_bus cyc=%0d actual=%h required=%h", cyc, mem_to_wb_bus, e.wb);
                end
                total++;
                if (mem_to_id_bus !== e.id) begin
                    bad++;
                    $display("FAIL id_bus cyc=%0d actual=%h required=%h", cyc, mem_to_id_bus, e.id);
                end
                total++;
                if (mem_addr_err !== e.err) begin
                    bad++;
                    $display("FAIL addr_err cyc=%0d actual=%b required=%b", cyc, mem_addr_err, e.err);
                end
                if (e.chk_hv) begin
                    total++;
                    if (dut.hold_valid_q !== e.hv) begin
                        bad++;
                        $display("FAIL hold_valid cyc=%0d actual=%b required=%b", cyc, dut.hold_valid_q, e.hv);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        stall              = GO;
        ex_to_mem_bus      = '0;
        load_sram_ex_data  = '0;
        store_sram_ex_data = '0;
        data_sram_rdata    = '0;

        @(posedge clk);
        #1;
        push_exp(0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back loads: each rdata goes with the following drive
        drive(mk_ex(32'h100, 1, 1, 5'd3, 32'h1003, 1), LB, 3'b000, 32'h0, GO);
        push_exp(1, 32'h100, 1, 5'd3, 32'hFFFF_FF80, 0, 1, 0);
        drive(mk_ex(32'h104, 1, 1, 5'd4, 32'h1003, 1), LBU, 3'b000, 32'h80FF_1234, GO);
        push_exp(1, 32'h104, 1, 5'd4, 32'h0000_0080, 0, 1, 0);
        drive(mk_ex(32'h108, 1, 1, 5'd5, 32'h2002, 1), LHU, 3'b000, 32'h80FF_1234, GO);
        push_exp(1, 32'h108, 1, 5'd5, 32'h0000_BEEF, 0, 1, 0);
        drive(mk_ex(32'h10C, 1, 1, 5'd6, 32'h2002, 1), LH, 3'b000, 32'hBEEF_0001, GO);
        push_exp(1, 32'h10C, 1, 5'd6, 32'hFFFF_BEEF, 0, 1, 0);
        drive(mk_ex(32'h110, 0, 1, 5'd0, 32'h5, 0), 5'b0, 3'b000, 32'hBEEF_0001, GO);
        push_exp(1, 32'h110, 1, 5'd0, 32'h5, 0, 0, 0);
        drive(mk_ex(32'h114, 0, 1, 5'd8, 32'h5, 0), 5'b0, 3'b000, 32'h0, GO);
        push_exp(1, 32'h114, 1, 5'd8, 32'h5, 0, 0, 0);
        drive(mk_ex(32'h118, 1, 1, 5'd9, 32'h3000, 1), LW, 3'b000, 32'h0, GO);
        push_exp(1, 32'h118, 1, 5'd9, 32'hCAFE_F00D, 0, 1, 0);
        drive(mk_ex(32'h11C, 0, 0, 5'd0, 32'h4000, 1), 5'b0, SW, 32'hCAFE_F00D, GO);
        push_exp(1, 32'h11C, 0, 5'd0, 32'h4000, 0, 0, 0);
        drive(mk_ex(32'h120, 1, 1, 5'd2, 32'h1001, 1), LB, 3'b000, 32'h0, GO);
        push_exp(1, 32'h120, 1, 5'd2, 32'h0000_0056, 0, 1, 0);
        drive(mk_ex(32'h500, 1, 1, 5'd15, 32'h1002, 1), LW, 3'b000, 32'h1234_5678, GO);
`ifdef MEM_ALIGN_CHK_EN
        push_exp(1, 32'h500, 0, 5'd15, 32'h1122_3344, 1, 1, 0);
`else
        push_exp(1, 32'h500, 1, 5'd15, 32'h1122_3344, 0, 1, 0);
`endif

        // load held across a 3-edge stall while SRAM data changes underneath
        drive(mk_ex(32'h200, 1, 1, 5'd10, 32'h5000, 1), LW, 3'b000, 32'h1122_3344, GO);
        push_exp(1, 32'h200, 1, 5'd10, 32'h1234_5678, 0, 1, 0);
        drive(mk_ex(32'hBAD, 0, 1, 5'd1, 32'h1, 0), 5'b0, 3'b000, 32'h1234_5678, HOLD);
        push_exp(1, 32'h200, 1, 5'd10, 32'h1234_5678, 0, 1, 1);
        drive(mk_ex(32'hBAD, 0, 1, 5'd1, 32'h1, 0), 5'b0, 3'b000, 32'hDEAD_DEAD, HOLD);
        push_exp(1, 32'h200, 1, 5'd10, 32'h1234_5678, 0, 1, 1);
        drive(mk_ex(32'hBAD, 0, 1, 5'd1, 32'h1, 0), 5'b0, 3'b000, 32'hDEAD_DEAD, HOLD);
        push_exp(1, 32'h200, 1, 5'd10, 32'h1234_5678, 0, 1, 1);
        drive(mk_ex(32'h204, 0, 1, 5'd11, 32'h77, 0), 5'b0, 3'b000, 32'hDEAD_DEAD, GO);
        push_exp(1, 32'h204, 1, 5'd11, 32'h77, 0, 1, 0);

        // bubble insertion, then hold
        drive(mk_ex(32'h300, 0, 1, 5'd12, 32'hAA, 0), 5'b0, 3'b000, 32'h0, GO);
        push_exp(1, 32'h300, 1, 5'd12, 32'hAA, 0, 0, 0);
        drive(mk_ex(32'hBAD, 0, 1, 5'd1, 32'h1, 0), 5'b0, 3'b000, 32'h0, BUBBLE);
        push_exp(1, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
        drive(mk_ex(32'h304, 0, 1, 5'd13, 32'hBB, 0), 5'b0, 3'b000, 32'h0, GO);
        push_exp(1, 32'h304, 1, 5'd13, 32'hBB, 0, 1, 0);
        drive(mk_ex(32'hBAD, 0, 1, 5'd1, 32'h1, 0), 5'b0, 3'b000, 32'h0, HOLD);
        push_exp(1, 32'h304, 1, 5'd13, 32'hBB, 0, 1, 0);

        // asynchronous reset in the middle of a stall with the hold buffer full
        drive(mk_ex(32'h400, 1, 1, 5'd14, 32'h6000, 1), LW, 3'b000, 32'h0, GO);
        push_exp(1, 32'h400, 1, 5'd14, 32'hA5A5_A5A5, 0, 1, 0);
        drive(mk_ex(32'hBAD, 0, 1, 5'd1, 32'h1, 0), 5'b0, 3'b000, 32'hA5A5_A5A5, HOLD);
        push_exp(1, 32'h400, 1, 5'd14, 32'hA5A5_A5A5, 0, 1, 1);
        drive(mk_ex(32'hBAD, 0, 1, 5'd1, 32'h1, 0), 5'b0, 3'b000, 32'h0, HOLD);
        drive(mk_ex(32'hBAD, 0, 1, 5'd1, 32'h1, 0), 5'b0, 3'b000, 32'h0, HOLD);
        #1;
        rst = 1'b1;
        push_exp(0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // store after reset: no write-back, ex_result passes through
        drive(mk_ex(32'h600, 0, 0, 5'd7, 32'h8000, 1), 5'b0, SW, 32'h0, GO);
        push_exp(1, 32'h600, 0, 5'd7, 32'h8000, 0, 1, 0);
        drive(mk_ex(32'h0, 0, 0, 5'd0, 32'h0, 0), 5'b0, 3'b000, 32'h0, GO);

        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage, directly upstream of write-back.
- Registers the EX→MEM bus and the load/store type flags, with stall and bubble insertion.
- Captures synchronous data-SRAM read data, including a hold buffer for multi-cycle stalls.
- Aligns and extends load data, selects the write-back value, and drives the MEM→WB bus and the MEM→ID forwarding bus.

Parameters:
- EX_TO_MEM_WD, 76: width of the incoming EX bus.
- MEM_TO_WB_WD, 70: width of the outgoing write-back bus.
- MEM_TO_ID_WD, 38: width of the forwarding bus.
- STALL_WD, 6: width of the stall vector.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- stall, input, STALL_WD: pipeline stall vector. Bit 3 controls this stage, bit 4 controls WB.
- ex_to_mem_bus, input, EX_TO_MEM_WD: {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- load_sram_ex_data, input, 5: {lb, lh, lw, lbu, lhu}, one-hot or zero.
- store_sram_ex_data, input, 3: {sb, sh, sw}, one-hot or zero.
- data_sram_rdata, input, 32: SRAM read data. Valid in the first cycle the load occupies MEM.
- mem_to_wb_bus, output, MEM_TO_WB_WD: {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_id_bus, output, MEM_TO_ID_WD: {rf_we, rf_waddr, rf_wdata}.
- mem_addr_err, output, 1: misaligned-access flag. Tied to 0 unless MEM_ALIGN_CHK_EN is defined.

Behaviour:
- Pipeline register covers the EX bus and the load/store flags.
  - rst asserted (asynchronous): all bits 0.
  - stall[3]=Stop and stall[4]=NoStop: load all zeros (bubble).
  - stall[3]=NoStop: capture the inputs.
  - Otherwise: hold.
- A bubble yields rf_we=0 and pc=0 on every output.
- Read-data hold buffer (hold_valid, hold_data):
  - Set: stage is stalled (stall[3]=Stop), the registered instruction is a load, and hold_valid=0. Action: hold_data<=data_sram_rdata, hold_valid<=1.
  - Clear: the stage advances (stall[3]=NoStop) or rst. Action: hold_valid<=0.
  - Effective rdata = hold_valid ? hold_data : data_sram_rdata.
  - rdata arriving in the first MEM cycle is therefore preserved across any stall length.
- Load alignment uses offset a = ex_result[1:0] and effective rdata.
  - lb: sign-extend byte a. lbu: zero-extend byte a.
  - lh: sign-extend half a[1] (a[1]=0 → bits 15:0, a[1]=1 → bits 31:16). lhu: zero-extend the same half.
  - lw: full word.
  - No load flag set: 0.
- rf_wdata = sel_rf_res ? aligned load data : ex_result.
- Outputs are combinational from the register and the hold buffer. Latency is 1 cycle from EX bus capture to valid outputs.
- Forwarding: mem_to_id_bus rf_we is forced to 0 when rf_waddr=0. mem_to_wb_bus passes rf_we unmodified.
- Store flags are registered only for the alignment check. Stores produce no write-back unless rf_we is set.
- Simultaneous rst and stall: rst wins.
- Back-to-back loads without a stall: the hold buffer is never set, and each load uses live rdata.
- A stall that begins on a non-load and ends on a load: the buffer captures only once the load occupies the stage.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - mem_addr_err=1 combinationally when a registered lh/lhu/sh has a[0]=1, or lw/sw has a≠0.
  - For a flagged load, rf_we is forced to 0 on both output buses.
- Not defined: mem_addr_err=0 and no write suppression. Misaligned data is extracted purely by offset.

Decomposition:
- Shared package/defines: bus widths (EX_TO_MEM_WD, MEM_TO_WB_WD, MEM_TO_ID_WD, LOAD_SRAM_DATA_WD=5, STORE_SRAM_DATA_WD=3), StallBus, Stop/NoStop, ZeroWord.
- Sub-module: load_align (combinational). Inputs: rdata, offset, 5 load flags. Output: 32-bit extended data.

Test Plan:
- lb at addr 0x1003 with rdata 0x80FF_1234: rf_wdata=0xFFFF_FF80. Same case with lbu: 0x0000_0080.
- lhu at addr 0x2002 with rdata 0xBEEF_0001: rf_wdata=0x0000_BEEF. Same case with lh: 0xFFFF_BEEF.
- Load enters MEM with rdata 0x1234_5678, stall[3]=Stop for 3 cycles while rdata changes to 0xDEAD_DEAD: rf_wdata stays 0x1234_5678. After advance, hold_valid=0.
- stall=6'b001111 for one edge: next cycle mem_to_wb_bus=0 (bubble). stall=6'b011111: register holds its prior value.
- ALU op rf_we=1, waddr=0, result 5: mem_to_id_bus we=0, mem_to_wb_bus we=1. With waddr=8: forwarding {1, 8, 5}.
- rst asserted asynchronously mid-stall with hold_valid=1: all outputs 0 and hold_valid=0 before the next edge. With MEM_ALIGN_CHK_EN, lw at 0x1002: mem_addr_err=1, rf_we=0.
